// File: rtl/axi_line_burst_engine_if.sv
// AXI4 master-port bundle used by the line burst engine.
// master: the engine (drives AR/AW/W, rready, bready); slave: the memory side.
interface axi_line_burst_engine_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;

  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;

  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;

  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;

  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rlast,
    output rready,
    output awvalid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp,
    output bready
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rlast,
    input  rready,
    input  awvalid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp,
    input  bready
  );
endinterface

// File: rtl/axi_line_burst_engine.sv
// Moves one cache line between the caches and an AXI4 port as a single INCR burst.
// Optional stall watchdog: define LBE_TIMEOUT_EN to abort a transaction that sees
// no AXI handshake for TIMEOUT_CYCLES cycles (reported as an error).
//
// state | meaning
// IDLE  | waiting for a read or write-back request
// AR    | read address presented
// R     | collecting read beats
// AW    | write address presented
// W     | sending write beats
// B     | waiting for the write response
// DONE  | one-cycle completion pulse, o_err valid
module axi_line_burst_engine #(
  parameter int ADDR_WIDTH     = 64,
  parameter int LINE_WIDTH     = 512,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_start_read,
  input  logic                  i_start_write,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [LINE_WIDTH-1:0] i_line_wdata,
  output logic [LINE_WIDTH-1:0] o_line_rdata,
  output logic                  o_done,
  output logic                  o_err,
  output logic                  o_busy,
  axi_line_burst_engine_if.master axi
);
  localparam int BEATS      = LINE_WIDTH / DATA_WIDTH;
  localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LINE_BYTES = LINE_WIDTH / 8;
  localparam int SIZE       = $clog2(DATA_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, DONE} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  err, err_nxt;
  logic [LINE_WIDTH-1:0] wline, wline_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [ADDR_WIDTH-1:0] addr_aligned;
  logic                  hs_ar, hs_r, hs_aw, hs_w, hs_b;
  logic                  timeout_hit;

  assign addr_aligned = i_addr & ~ADDR_WIDTH'(LINE_BYTES - 1);
  assign hs_ar = axi.arvalid & axi.arready;
  assign hs_r  = axi.rvalid  & axi.rready;
  assign hs_aw = axi.awvalid & axi.awready;
  assign hs_w  = axi.wvalid  & axi.wready;
  assign hs_b  = axi.bvalid  & axi.bready;

  // Ready signals follow the state directly so a beat is never missed.
  assign axi.rready  = (state == R);
  assign axi.bready  = (state == B);
  assign axi.arlen   = 8'(BEATS - 1);
  assign axi.awlen   = 8'(BEATS - 1);
  assign axi.arsize  = 3'(SIZE);
  assign axi.awsize  = 3'(SIZE);
  assign axi.arburst = 2'b01;
  assign axi.awburst = 2'b01;
  assign axi.wstrb   = '1;

`ifdef LBE_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_cnt;
  logic             waiting, any_hs;

  assign waiting     = (state == AR) || (state == R) || (state == AW) ||
                       (state == W)  || (state == B);
  assign any_hs      = hs_ar | hs_r | hs_aw | hs_w | hs_b;
  assign timeout_hit = waiting && !any_hs && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Stall watchdog: counts handshake-free cycles while a transaction is open.
  always_ff @(posedge clk) begin
    if (i_rst || any_hs || !waiting) tmo_cnt <= '0;
    else                             tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  logic unused_tmo;
  // The stall limit has no effect when the watchdog is compiled out.
  assign unused_tmo  = (TIMEOUT_CYCLES == 0);
  assign timeout_hit = 1'b0;
`endif

  // Next-state, beat counter, sticky error and request capture.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = err;
    wline_nxt = wline;
    addr_nxt  = addr_q;
    case (state)
      IDLE: begin
        if (i_start_write || i_start_read) begin
          state_nxt = i_start_write ? AW : AR;
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
          addr_nxt  = addr_aligned;
          if (i_start_write) wline_nxt = i_line_wdata;
        end
      end
      AR: if (hs_ar) state_nxt = R;
      R: begin
        if (hs_r) begin
          cnt_nxt = cnt + 1'b1;
          if ((axi.rresp != 2'b00) || (axi.rlast != (cnt == LAST))) err_nxt = 1'b1;
          if (cnt == LAST) state_nxt = DONE;
        end
      end
      AW: if (hs_aw) state_nxt = W;
      W: begin
        if (hs_w) begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST) state_nxt = B;
        end
      end
      B: begin
        if (hs_b) begin
          if (axi.bresp != 2'b00) err_nxt = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: state_nxt = IDLE;
    endcase
    if (timeout_hit) begin
      state_nxt = DONE;
      err_nxt   = 1'b1;
    end
  end

  // State register; all bus and status outputs are registered from next-state values.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      err         <= 1'b0;
      wline       <= '0;
      addr_q      <= '0;
      axi.arvalid <= 1'b0;
      axi.awvalid <= 1'b0;
      axi.wvalid  <= 1'b0;
      axi.wlast   <= 1'b0;
      axi.wdata   <= '0;
      axi.araddr  <= '0;
      axi.awaddr  <= '0;
      o_done      <= 1'b0;
      o_busy      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      err         <= err_nxt;
      wline       <= wline_nxt;
      addr_q      <= addr_nxt;
      axi.arvalid <= (state_nxt == AR);
      axi.awvalid <= (state_nxt == AW);
      axi.wvalid  <= (state_nxt == W);
      axi.wlast   <= (state_nxt == W) && (cnt_nxt == LAST);
      axi.wdata   <= wline_nxt[cnt_nxt*DATA_WIDTH +: DATA_WIDTH];
      axi.araddr  <= addr_nxt;
      axi.awaddr  <= addr_nxt;
      o_done      <= (state_nxt == DONE);
      o_busy      <= (state_nxt != IDLE);
      o_err       <= (state_nxt == DONE) && err_nxt;
    end
  end

  // Refill buffer: each accepted read beat lands in its slot; write-backs leave it alone.
  always_ff @(posedge clk) begin
    if (i_rst) o_line_rdata <= '0;
    else if (hs_r && (state == R)) o_line_rdata[cnt*DATA_WIDTH +: DATA_WIDTH] <= axi.rdata;
  end
endmodule

// File: tb/tb_axi_line_burst_engine.sv
// Randomised bench for axi_line_burst_engine (512-bit line, 64-bit bus).
// The memory side is driven procedurally; expectations come from a line-level model.
module tb_axi_line_burst_engine;
  localparam int AW    = 64;
  localparam int LW    = 512;
  localparam int DW    = 64;
  localparam int BEATS = LW / DW;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_start_read, i_start_write;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_line_wdata;
  logic [LW-1:0] o_line_rdata;
  logic          o_done, o_err, o_busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [LW-1:0] model_line;

  axi_line_burst_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  axi_line_burst_engine #(
    .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk(clk), .i_rst(i_rst),
    .i_start_read(i_start_read), .i_start_write(i_start_write),
    .i_addr(i_addr), .i_line_wdata(i_line_wdata),
    .o_line_rdata(o_line_rdata), .o_done(o_done), .o_err(o_err), .o_busy(o_busy),
    .axi(axi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    model_line = '0;
  endtask

  // err_mode: 0 clean, 1 random rresp/rlast faults, 2 SLVERR on beat 3.
  // abort_after: beat index after whose handshake reset is applied (-1 = none).
  task automatic do_read(input logic [AW-1:0] addr, input int stall, input bit directed,
                         input int err_mode, input int abort_after);
    logic [DW-1:0] beats [BEATS];
    logic [1:0]    resp  [BEATS];
    bit            lbad  [BEATS];
    bit            exp_err;
    bit            hs;
    int            k, guard;
    logic [LW-1:0] exp_line;
    exp_err = 0;
    for (int b = 0; b < BEATS; b++) begin
      beats[b] = directed ? DW'(64'h1111 * b) : {$urandom, $urandom};
      resp[b]  = 2'b00;
      lbad[b]  = 0;
      if (err_mode == 1) begin
        if ($urandom_range(0, 5) == 0) resp[b] = 2'b10;
        if ($urandom_range(0, 7) == 0) lbad[b] = 1;
      end
      if (err_mode == 2 && b == 3) resp[b] = 2'b10;
      exp_err = exp_err | (resp[b] != 2'b00) | lbad[b];
      exp_line[b*DW +: DW] = beats[b];
    end

    i_addr = addr;
    i_start_read = 1'b1;
    tick();
    i_start_read = 1'b0;
    i_addr = {$urandom, $urandom};
    chk("rd_arvalid_rise", axi.arvalid, 1);
    chk("rd_awvalid_low", axi.awvalid, 0);
    chk("rd_busy", o_busy, 1);
    chk("rd_araddr", axi.araddr, addr & ~64'h3f);
    chk("rd_arlen", axi.arlen, 7);
    chk("rd_arsize", axi.arsize, 3);
    chk("rd_arburst", axi.arburst, 1);

    hs = 0;
    for (guard = 0; guard < 500 && !hs; guard++) begin
      chk("rd_arvalid_hold", axi.arvalid, 1);
      axi.arready = ($urandom_range(0, 99) >= stall);
      hs = axi.arvalid && axi.arready;
      tick();
    end
    axi.arready = 1'b0;
    if (!hs) chk("rd_ar_budget", 0, 1);

    k = 0;
    guard = 0;
    while (k < BEATS && guard < 2000) begin
      chk("rd_rready", axi.rready, 1);
      chk("rd_done_low", o_done, 0);
      chk("rd_arvalid_low", axi.arvalid, 0);
      axi.rvalid = ($urandom_range(0, 99) >= stall);
      axi.rdata  = axi.rvalid ? beats[k] : {$urandom, $urandom};
      axi.rresp  = resp[k];
      axi.rlast  = (k == BEATS - 1) ^ lbad[k];
      hs = axi.rvalid && axi.rready;
      tick();
      guard++;
      if (hs) begin
        if (k == abort_after) begin
          axi.rvalid = 1'b0;
          i_rst = 1'b1;
          tick();
          chk("rst_rready", axi.rready, 0);
          chk("rst_busy", o_busy, 0);
          chk("rst_done", o_done, 0);
          chk("rst_line", o_line_rdata, 0);
          i_rst = 1'b0;
          model_line = '0;
          return;
        end
        k++;
      end
    end
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    if (k < BEATS) chk("rd_r_budget", k, BEATS);
    model_line = exp_line;
    chk("rd_done", o_done, 1);
    chk("rd_err", o_err, exp_err);
    chk("rd_busy_done", o_busy, 1);
    chk("rd_line", o_line_rdata, model_line);
    tick();
    chk("rd_done_pulse", o_done, 0);
    chk("rd_busy_end", o_busy, 0);
    chk("rd_line_hold", o_line_rdata, model_line);
  endtask

  // toggle: wready alternates 1/0 starting at 1; both: read request raised with the write.
  task automatic do_write(input logic [AW-1:0] addr, input int stall, input bit toggle,
                          input bit bad_resp, input bit both);
    logic [LW-1:0] wl;
    bit            hs, tog;
    int            k, guard;
    for (int i = 0; i < LW / 32; i++) wl[i*32 +: 32] = $urandom;

    i_addr = addr;
    i_line_wdata = wl;
    i_start_write = 1'b1;
    i_start_read = both;
    tick();
    i_start_write = 1'b0;
    i_start_read = 1'b0;
    i_line_wdata = '1;
    chk("wr_awvalid_rise", axi.awvalid, 1);
    chk("wr_arvalid_low", axi.arvalid, 0);
    chk("wr_busy", o_busy, 1);
    chk("wr_awaddr", axi.awaddr, addr & ~64'h3f);
    chk("wr_awlen", axi.awlen, 7);
    chk("wr_awsize", axi.awsize, 3);
    chk("wr_awburst", axi.awburst, 1);

    hs = 0;
    for (guard = 0; guard < 500 && !hs; guard++) begin
      chk("wr_awvalid_hold", axi.awvalid, 1);
      chk("wr_ar_idle", axi.arvalid, 0);
      axi.awready = ($urandom_range(0, 99) >= stall);
      hs = axi.awvalid && axi.awready;
      tick();
    end
    axi.awready = 1'b0;
    if (!hs) chk("wr_aw_budget", 0, 1);

    k = 0;
    guard = 0;
    tog = 1;
    while (k < BEATS && guard < 2000) begin
      chk("wr_wvalid", axi.wvalid, 1);
      chk("wr_wdata", axi.wdata, wl[k*DW +: DW]);
      chk("wr_wlast", axi.wlast, (k == BEATS - 1));
      chk("wr_wstrb", axi.wstrb, 8'hff);
      chk("wr_ar_idle", axi.arvalid, 0);
      axi.wready = toggle ? tog : ($urandom_range(0, 99) >= stall);
      tog = !tog;
      i_start_read = ($urandom_range(0, 3) == 0);
      hs = axi.wvalid && axi.wready;
      tick();
      guard++;
      if (hs) k++;
    end
    axi.wready = 1'b0;
    i_start_read = 1'b0;
    if (k < BEATS) chk("wr_w_budget", k, BEATS);

    hs = 0;
    for (guard = 0; guard < 500 && !hs; guard++) begin
      chk("wr_bready", axi.bready, 1);
      chk("wr_wvalid_low", axi.wvalid, 0);
      axi.bvalid = ($urandom_range(0, 99) >= stall);
      axi.bresp  = bad_resp ? 2'b10 : 2'b00;
      hs = axi.bvalid;
      tick();
    end
    axi.bvalid = 1'b0;
    axi.bresp  = 2'b00;
    if (!hs) chk("wr_b_budget", 0, 1);

    chk("wr_done", o_done, 1);
    chk("wr_err", o_err, bad_resp);
    chk("wr_ar_idle_done", axi.arvalid, 0);
    chk("wr_line_untouched", o_line_rdata, model_line);
    tick();
    chk("wr_done_pulse", o_done, 0);
    chk("wr_busy_end", o_busy, 0);
    chk("wr_ar_after", axi.arvalid, 0);
  endtask

  task automatic do_timeout();
    int  t;
    bit  ar_all, busy_all;
    i_addr = {$urandom, $urandom};
    i_start_read = 1'b1;
    tick();
    i_start_read = 1'b0;
    axi.arready = 1'b0;
    t = 1;
    chk("tmo_arvalid_rise", axi.arvalid, 1);
`ifdef LBE_TIMEOUT_EN
    while (t < 2000 && !o_done) begin
      tick();
      t++;
    end
    chk("tmo_cycle", t, 1025);
    chk("tmo_err", o_err, 1);
    chk("tmo_arvalid_drop", axi.arvalid, 0);
    tick();
    chk("tmo_busy_end", o_busy, 0);
`else
    ar_all = 1;
    busy_all = 1;
    while (t < 2001) begin
      tick();
      t++;
      ar_all   = ar_all & axi.arvalid;
      busy_all = busy_all & o_busy;
    end
    chk("hang_arvalid", ar_all, 1);
    chk("hang_busy", busy_all, 1);
    chk("hang_no_done", o_done, 0);
`endif
    do_reset();
  endtask

  initial begin
    i_rst = 1'b1;
    i_start_read = 1'b0;
    i_start_write = 1'b0;
    i_addr = '0;
    i_line_wdata = '0;
    axi.arready = 1'b0;
    axi.rvalid = 1'b0;
    axi.rdata = '0;
    axi.rresp = 2'b00;
    axi.rlast = 1'b0;
    axi.awready = 1'b0;
    axi.wready = 1'b0;
    axi.bvalid = 1'b0;
    axi.bresp = 2'b00;
    model_line = '0;
    tick();
    tick();
    tick();
    i_rst = 1'b0;
    chk("rst_arvalid", axi.arvalid, 0);
    chk("rst_awvalid", axi.awvalid, 0);
    chk("rst_wvalid", axi.wvalid, 0);
    chk("rst_rready", axi.rready, 0);
    chk("rst_bready", axi.bready, 0);
    chk("rst_status", {o_busy, o_done, o_err}, 0);
    chk("rst_line0", o_line_rdata, 0);
    tick();

    do_read(64'h8000_1234, 0, 1, 0, -1);
    do_write({$urandom, $urandom}, 0, 1, 0, 0);
    do_write({$urandom, $urandom}, 20, 0, 0, 1);
    do_read({$urandom, $urandom}, 30, 0, 2, -1);
    do_read({$urandom, $urandom}, 0, 0, 0, -1);
    do_read({$urandom, $urandom}, 20, 0, 0, 4);
    do_read({$urandom, $urandom}, 10, 0, 0, -1);
    do_write({$urandom, $urandom}, 0, 0, 1, 0);

    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 0)
        do_read({$urandom, $urandom}, $urandom_range(0, 60), 0, $urandom_range(0, 1), -1);
      else
        do_write({$urandom, $urandom}, $urandom_range(0, 60), 0, ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) tick();
    end

    do_timeout();
    do_read({$urandom, $urandom}, 10, 0, 0, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
